// File: rtl/rbus_stop_sched_if.sv
// Bundle of requester, ring and credit signals for one rbus stop scheduler.
// master = local requesters + ring stop side; slave = the scheduler.
interface rbus_stop_sched_if #(
  parameter int CW = 4
);
  logic          req0_valid;
  logic          req0_two_beat;
  logic          req0_grant;
  logic          req0_doStall;
  logic          req1_valid;
  logic          req1_two_beat;
  logic          req1_grant;
  logic          req1_doStall;
  logic          ring_rdyIn;
  logic          rdyOutA;
  logic          rdyOutB;
  logic          rsp_ret0;
  logic          rsp_ret1;
  logic [CW-1:0] out_cnt0;
  logic [CW-1:0] out_cnt1;
  logic          cred_err;

  modport master (
    output req0_valid, req0_two_beat, req1_valid, req1_two_beat,
    output ring_rdyIn, rsp_ret0, rsp_ret1,
    input  req0_grant, req0_doStall, req1_grant, req1_doStall,
    input  rdyOutA, rdyOutB, out_cnt0, out_cnt1, cred_err
  );

  modport slave (
    input  req0_valid, req0_two_beat, req1_valid, req1_two_beat,
    input  ring_rdyIn, rsp_ret0, rsp_ret1,
    output req0_grant, req0_doStall, req1_grant, req1_doStall,
    output rdyOutA, rdyOutB, out_cnt0, out_cnt1, cred_err
  );
endinterface

// File: rtl/rbus_stop_sched.sv
// Round-robin injection scheduler for one rbus ring stop with two-beat locking
// and per-requester credits. Optional age priority: RBUS_SCHED_AGE_PRIO_EN.
module rbus_stop_sched #(
  parameter int MAX_OUT   = 8,
  parameter int CW        = 4,
  parameter int STALL_CNT = 19
) (
  input logic               clk,
  input logic               rst,
  rbus_stop_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic          credErr_q, credErr_d;

  logic elig0, elig1;
  logic win0, win1;
  logic grant0, grant1;
  logic inc0, inc1;
  logic starved0, starved1;

`ifdef RBUS_SCHED_AGE_PRIO_EN
  logic [4:0] wait0_q, wait0_d;
  logic [4:0] wait1_q, wait1_d;
  logic       stall0_q, stall1_q;

  // Wait counters track consecutive ungranted cycles and saturate at the starvation mark.
  always_comb begin
    wait0_d = wait0_q;
    wait1_d = wait1_q;
    if (!bus.req0_valid || grant0)       wait0_d = '0;
    else if (wait0_q != 5'(STALL_CNT))   wait0_d = wait0_q + 5'd1;
    if (!bus.req1_valid || grant1)       wait1_d = '0;
    else if (wait1_q != 5'(STALL_CNT))   wait1_d = wait1_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait0_q  <= '0;
      wait1_q  <= '0;
      stall0_q <= 1'b0;
      stall1_q <= 1'b0;
    end else begin
      wait0_q  <= wait0_d;
      wait1_q  <= wait1_d;
      stall0_q <= (wait0_d == 5'(STALL_CNT));
      stall1_q <= (wait1_d == 5'(STALL_CNT));
    end
  end

  assign starved0 = stall0_q;
  assign starved1 = stall1_q;
`else
  assign starved0 = 1'b0;
  assign starved1 = 1'b0;
`endif

  assign elig0 = bus.req0_valid && (cnt0_q < CW'(MAX_OUT));
  assign elig1 = bus.req1_valid && (cnt1_q < CW'(MAX_OUT));

  // A lock bypasses both credits and priority; otherwise starvation beats rr.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    case (state_q)
      LOCK0:   win0 = bus.req0_valid;
      LOCK1:   win1 = bus.req1_valid;
      default: begin
        if (elig0 && elig1) begin
          if (starved0 && !starved1)      win0 = 1'b1;
          else if (starved1 && !starved0) win1 = 1'b1;
          else if (rr_q)                  win1 = 1'b1;
          else                            win0 = 1'b1;
        end else begin
          win0 = elig0;
          win1 = elig1;
        end
      end
    endcase
  end

  assign grant0 = !rst && bus.ring_rdyIn && win0;
  assign grant1 = !rst && bus.ring_rdyIn && win1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      LOCK0: if (grant0) state_d = IDLE;
      LOCK1: if (grant1) state_d = IDLE;
      default: begin
        if (grant0) begin
          rr_d = 1'b1;
          if (bus.req0_two_beat) state_d = LOCK0;
        end else if (grant1) begin
          rr_d = 1'b0;
          if (bus.req1_two_beat) state_d = LOCK1;
        end
      end
    endcase
  end

  assign inc0 = grant0 && (state_q == IDLE);
  assign inc1 = grant1 && (state_q == IDLE);

  // Only first beats consume a credit; a simultaneous return cancels it out.
  always_comb begin
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    credErr_d = credErr_q;
    if (inc0 && !bus.rsp_ret0) begin
      cnt0_d = cnt0_q + CW'(1);
    end else if (!inc0 && bus.rsp_ret0) begin
      if (cnt0_q == '0) credErr_d = 1'b1;
      else              cnt0_d    = cnt0_q - CW'(1);
    end
    if (inc1 && !bus.rsp_ret1) begin
      cnt1_d = cnt1_q + CW'(1);
    end else if (!inc1 && bus.rsp_ret1) begin
      if (cnt1_q == '0) credErr_d = 1'b1;
      else              cnt1_d    = cnt1_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      credErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      credErr_q <= credErr_d;
    end
  end

  assign bus.req0_grant = grant0;
  assign bus.req1_grant = grant1;
  assign bus.rdyOutA    = grant0;
  assign bus.rdyOutB    = grant1;
  assign bus.out_cnt0   = cnt0_q;
  assign bus.out_cnt1   = cnt1_q;
  assign bus.cred_err   = credErr_q;
`ifdef RBUS_SCHED_AGE_PRIO_EN
  assign bus.req0_doStall = stall0_q;
  assign bus.req1_doStall = stall1_q;
`else
  assign bus.req0_doStall = 1'b0;
  assign bus.req1_doStall = 1'b0;
`endif

endmodule

// File: tb/tb_rbus_stop_sched.sv
// Directed bench for rbus_stop_sched: round-robin, locking, credits, reset, starvation.
// Expected doStall values follow RBUS_SCHED_AGE_PRIO_EN when it is defined.
module tb_rbus_stop_sched;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic stallExp;

  rbus_stop_sched_if #(.CW(4)) bus ();

  rbus_stop_sched #(.MAX_OUT(8), .CW(4), .STALL_CNT(19)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  // grants checked as {rdyOutA, rdyOutB} mirrored onto {req0_grant, req1_grant}
  task automatic checkGrant(input string tag, input logic [1:0] exp);
    checkOutput(tag, {28'd0, bus.rdyOutA, bus.rdyOutB, bus.req0_grant, bus.req1_grant}, {28'd0, exp, exp});
  endtask

  task automatic applyStimulus(input logic v0, input logic t0, input logic v1, input logic t1,
                               input logic rdy, input logic r0, input logic r1);
    bus.req0_valid    = v0;
    bus.req0_two_beat = t0;
    bus.req1_valid    = v1;
    bus.req1_two_beat = t1;
    bus.ring_rdyIn    = rdy;
    bus.rsp_ret0      = r0;
    bus.rsp_ret1      = r1;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
`ifdef RBUS_SCHED_AGE_PRIO_EN
    stallExp = 1'b1;
`else
    stallExp = 1'b0;
`endif
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_cnt0", 32'(bus.out_cnt0), 0);
    checkOutput("rst_cnt1", 32'(bus.out_cnt1), 0);
    checkOutput("rst_credErr", 32'(bus.cred_err), 0);
    checkOutput("rst_stall", {30'd0, bus.req0_doStall, bus.req1_doStall}, 0);
    checkGrant("rst_grant", 2'b00);
    rst = 1'b0;

    // alternating grants with both requesters valid
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 0, 1, 0, 0);
      checkGrant($sformatf("rr_%0d", i), (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    checkOutput("rr_cnt0", 32'(bus.out_cnt0), 2);
    checkOutput("rr_cnt1", 32'(bus.out_cnt1), 2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      tick();
    end
    checkOutput("drain_cnt0", 32'(bus.out_cnt0), 0);

    // two-beat lock on requester 0
    applyStimulus(1, 1, 1, 0, 1, 0, 0);
    checkGrant("lock_first", 2'b10);
    tick();
    applyStimulus(1, 0, 1, 0, 1, 0, 0);
    checkGrant("lock_second", 2'b10);
    tick();
    checkOutput("lock_cnt0", 32'(bus.out_cnt0), 1);
    applyStimulus(1, 0, 1, 0, 1, 0, 0);
    checkGrant("lock_release", 2'b01);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    tick();

    // credit exhaustion on requester 0
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      checkGrant($sformatf("fill_%0d", i), 2'b10);
      tick();
    end
    checkOutput("full_cnt0", 32'(bus.out_cnt0), 8);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkGrant("full_blocked", 2'b00);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    checkGrant("full_ret_same", 2'b00);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("ret_cnt0", 32'(bus.out_cnt0), 7);
    checkGrant("ret_grant", 2'b10);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      tick();
    end
    checkOutput("drain3_cnt0", 32'(bus.out_cnt0), 3);

    // grant and return together, then return with no credit
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    checkGrant("same_grant", 2'b10);
    tick();
    checkOutput("same_cnt0", 32'(bus.out_cnt0), 3);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    tick();
    checkOutput("underflow_err", 32'(bus.cred_err), 1);
    checkOutput("underflow_cnt1", 32'(bus.out_cnt1), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("sticky_err", 32'(bus.cred_err), 1);

    // reset while locked to requester 1
    applyStimulus(0, 0, 1, 1, 1, 0, 0);
    checkGrant("lock1_first", 2'b01);
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    checkGrant("rst_lock_grant", 2'b00);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkGrant("post_rst_grant", 2'b00);
    checkOutput("post_rst_cnt0", 32'(bus.out_cnt0), 0);
    checkOutput("post_rst_cnt1", 32'(bus.out_cnt1), 0);
    checkOutput("post_rst_err", 32'(bus.cred_err), 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkGrant("post_rst_idle", 2'b10);
    tick();

    // starvation with the ring stalled
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 0);
      if (i == 0) checkGrant("stall_nogrant", 2'b00);
      tick();
    end
    checkOutput("stall_both", {30'd0, bus.req0_doStall, bus.req1_doStall}, {30'd0, stallExp, stallExp});
    applyStimulus(1, 0, 1, 0, 1, 0, 0);
    checkGrant("stall_rr", 2'b10);
    tick();
    checkOutput("stall_after", {30'd0, bus.req0_doStall, bus.req1_doStall}, {30'd0, 1'b0, stallExp});
    applyStimulus(1, 0, 1, 0, 1, 0, 0);
    checkGrant("stall_next", 2'b01);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
